mc_control: RTL and testbench

- Multicycle main controller for the on-board MIPS core.
- Sequences PC, instruction register, memory, ALU and register file through fetch, decode, execute, memory and writeback steps.
- Drives the register-file write enable and destination select, including rt, rd and $31 (jal) destinations.
- Handshakes with a variable-latency memory, counts retired instructions, and flags illegal opcodes.

---
 rtl/mips_ctrl_pkg.sv | 67 ++++++
 rtl/mc_control_alu_decoder.sv | 23 ++
 rtl/mc_control.sv | 205 ++++++++++++++++++++
 tb/tb_mc_control.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcode/funct
// values and the datapath mux/ALU select encodings.
package mips_ctrl_pkg;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_RXEC   = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_BEQ    = 4'd9;
  localparam logic [3:0] S_IXEC   = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_JMP    = 4'd12;
  localparam logic [3:0] S_JAL    = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SRCB_REG   = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'b00,
    M2R_MDR    = 2'b01,
    M2R_PC     = 2'b10
  } mem_to_reg_e;

  typedef enum logic [1:0] {
    RDST_RD = 2'b00,
    RDST_RT = 2'b01,
    RDST_RA = 2'b11
  } reg_dst_e;

endpackage

// File: rtl/mc_control_alu_decoder.sv
// R-type funct field to ALU operation; valid_o drops for unsupported functs.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       valid_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    valid_o    = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      default: valid_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main controller: fetch/decode/execute/memory/writeback FSM
// with a memory handshake, retired-instruction counter and illegal-op flag.
module mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic [2:0]       dec_alu_ctrl;
  logic             dec_valid;

  alu_decoder u_alu_decoder (
    .funct_i    (funct),
    .alu_ctrl_o (dec_alu_ctrl),
    .valid_o    (dec_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign state_o = state_q;
  assign instret = instret_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_ctrl   = ALU_AND;
    mem_to_reg = M2R_ALUOUT;
    reg_write  = 1'b0;
    reg_dst    = RDST_RD;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALU_ADD;
        pc_src    = PCSRC_ALU;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end

      // ALU precomputes the branch target into ALUOut while op is decoded.
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        alu_ctrl  = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_IXEC;
          OP_J:         state_d = S_JMP;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        reg_dst    = RDST_RT;
        mem_to_reg = M2R_MDR;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      // Unknown funct aborts here so no writeback state is ever entered.
      S_RXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_ctrl  = dec_alu_ctrl;
        if (dec_valid) begin
          state_d = S_RWB;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = RDST_RD;
        mem_to_reg = M2R_ALUOUT;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_ctrl  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_IXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        state_d   = S_IWB;
      end

      S_IWB: begin
        reg_write  = 1'b1;
        reg_dst    = RDST_RT;
        mem_to_reg = M2R_ALUOUT;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_JMP: begin
        pc_src  = PCSRC_JUMP;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      // PC was already advanced in FETCH, so it supplies the link address.
      S_JAL: begin
        reg_write  = 1'b1;
        reg_dst    = RDST_RA;
        mem_to_reg = M2R_PC;
        pc_src     = PCSRC_JUMP;
        pc_en      = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus a randomized
// instruction stream, checked cycle by cycle against a per-instruction model.
module tb_mc_control;
  import mips_ctrl_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       op = '0;
  logic [5:0]       funct = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b1;
  logic             mem_req, mem_we, iord, ir_write, pc_en;
  logic [1:0]       pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_ctrl;
  logic [1:0]       mem_to_reg;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic             illegal, retire;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state_o;

  mc_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .reg_dst(reg_dst), .illegal(illegal), .retire(retire),
    .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       illegal;
    logic       retire;
    logic [3:0] state;
  } exp_t;

  int         checks = 0;
  int         failures = 0;
  logic [31:0] exp_instret = '0;

  function automatic exp_t sample();
    sample = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
              alu_ctrl, mem_to_reg, reg_write, reg_dst, illegal, retire, state_o};
  endfunction

  function automatic exp_t blank(input logic [3:0] st);
    blank = '0;
    blank.state = st;
  endfunction

  // Reference ALU operation per funct; valid=0 for anything unsupported.
  function automatic logic [3:0] ref_funct(input logic [5:0] f);
    case (f)
      6'b100000: ref_funct = {1'b1, 3'b010};
      6'b100010: ref_funct = {1'b1, 3'b110};
      6'b100100: ref_funct = {1'b1, 3'b000};
      6'b100101: ref_funct = {1'b1, 3'b001};
      6'b101010: ref_funct = {1'b1, 3'b111};
      default:   ref_funct = {1'b0, 3'b000};
    endcase
  endfunction

  // One clock cycle: drive mem_ready, compare all outputs at the falling edge.
  task automatic step(input exp_t e, input logic rdy, input logic mask_alu, input string tag);
    logic [23:0] act_v, exp_v, m;
    exp_t mk;
    mk = '1;
    if (mask_alu) mk.alu_ctrl = 3'b000;
    m = mk;
    mem_ready = rdy;
    @(negedge clk);
    act_v = sample();
    exp_v = e;
    checks++;
    if ((act_v & m) !== (exp_v & m)) begin
      failures++;
      $display("FAIL %s: outputs got %h required %h", tag, act_v & m, exp_v & m);
    end
    if (e.retire) exp_instret = exp_instret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_instret(input string tag);
    checks++;
    if (instret !== exp_instret) begin
      failures++;
      $display("FAIL %s instret: got %0d required %0d", tag, instret, exp_instret);
    end
  endtask

  // Runs one instruction from FETCH to completion (or abort) against the model.
  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int fl, input int ml, input bit abort, input string nm);
    exp_t e;
    logic [3:0] fr;
    logic known;
    op = o; funct = f; zero = z;
    for (int i = 0; i <= fl; i++) begin
      e = blank(S_FETCH); e.mem_req = 1; e.alu_src_b = 2'b01; e.alu_ctrl = 3'b010;
      if (i == fl) begin e.ir_write = 1; e.pc_en = 1; end
      step(e, i == fl, 0, {nm, "/fetch"});
    end
    known = (o == OP_LW) || (o == OP_SW) || (o == OP_RTYPE) || (o == OP_BEQ) ||
            (o == OP_ADDI) || (o == OP_J) || (o == OP_JAL);
    e = blank(S_DECODE); e.alu_src_b = 2'b11; e.alu_ctrl = 3'b010; e.illegal = !known;
    step(e, 1'($urandom_range(0, 1)), 0, {nm, "/decode"});
    if (known) begin
      case (o)
        OP_LW, OP_SW: begin
          e = blank(S_MEMADR); e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010;
          step(e, 1'($urandom_range(0, 1)), 0, {nm, "/memadr"});
          for (int i = 0; i <= ml; i++) begin
            if (abort && i == 1) begin
              mem_ready = 0;
              #2 rst_n = 0;
              #1;
              checks++;
              if (sample() !== exp_t'(0)) begin
                failures++;
                $display("FAIL %s/async_reset: outputs got %h required 0", nm, sample());
              end
              exp_instret = '0;
              check_instret({nm, "/async_reset"});
              return;
            end
            e = blank(o == OP_SW ? S_MEMWR : S_MEMRD);
            e.mem_req = 1; e.iord = 1; e.mem_we = (o == OP_SW);
            e.retire = (o == OP_SW) && (i == ml);
            step(e, i == ml, 0, {nm, "/mem"});
          end
          if (o == OP_LW) begin
            e = blank(S_MEMWB); e.reg_write = 1; e.reg_dst = 2'b01; e.mem_to_reg = 2'b01;
            e.retire = 1;
            step(e, 1'($urandom_range(0, 1)), 0, {nm, "/memwb"});
          end
        end
        OP_RTYPE: begin
          fr = ref_funct(f);
          e = blank(S_RXEC); e.alu_src_a = 1; e.alu_ctrl = fr[2:0]; e.illegal = !fr[3];
          step(e, 1'($urandom_range(0, 1)), !fr[3], {nm, "/rxec"});
          if (fr[3]) begin
            e = blank(S_RWB); e.reg_write = 1; e.retire = 1;
            step(e, 1'($urandom_range(0, 1)), 0, {nm, "/rwb"});
          end
        end
        OP_BEQ: begin
          e = blank(S_BEQ); e.alu_src_a = 1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01;
          e.pc_en = z; e.retire = 1;
          step(e, 1'($urandom_range(0, 1)), 0, {nm, "/beq"});
        end
        OP_ADDI: begin
          e = blank(S_IXEC); e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010;
          step(e, 1'($urandom_range(0, 1)), 0, {nm, "/ixec"});
          e = blank(S_IWB); e.reg_write = 1; e.reg_dst = 2'b01; e.retire = 1;
          step(e, 1'($urandom_range(0, 1)), 0, {nm, "/iwb"});
        end
        OP_J: begin
          e = blank(S_JMP); e.pc_src = 2'b10; e.pc_en = 1; e.retire = 1;
          step(e, 1'($urandom_range(0, 1)), 0, {nm, "/jmp"});
        end
        default: begin
          e = blank(S_JAL); e.reg_write = 1; e.reg_dst = 2'b11; e.mem_to_reg = 2'b10;
          e.pc_src = 2'b10; e.pc_en = 1; e.retire = 1;
          step(e, 1'($urandom_range(0, 1)), 0, {nm, "/jal"});
        end
      endcase
    end
    check_instret(nm);
    $display("instr %s op=%b funct=%b zero=%0d fetch_wait=%0d mem_wait=%0d instret=%0d",
             nm, o, f, z, fl, ml, instret);
  endtask

  // Expects rst_n low; releases it and checks the single IDLE cycle.
  task automatic release_reset(input string nm);
    checks++;
    if (sample() !== exp_t'(0)) begin
      failures++;
      $display("FAIL %s/in_reset: outputs got %h required 0", nm, sample());
    end
    exp_instret = '0;
    check_instret({nm, "/in_reset"});
    rst_n = 1;
    step(blank(S_IDLE), 1, 0, {nm, "/idle"});
  endtask

  task automatic test_reset();
    mem_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    release_reset("reset");
    do_instr(OP_J, 6'd0, 0, 0, 0, 0, "reset_first_j");
  endtask

  task automatic test_rtype_add();
    do_instr(OP_RTYPE, FN_ADD, 0, 0, 0, 0, "rtype_add");
  endtask

  task automatic test_lw_slow();
    do_instr(OP_LW, 6'd0, 0, 3, 3, 0, "lw_slow");
    do_instr(OP_SW, 6'd0, 0, 2, 2, 0, "sw_slow");
  endtask

  task automatic test_beq();
    do_instr(OP_BEQ, 6'd0, 1, 0, 0, 0, "beq_taken");
    do_instr(OP_BEQ, 6'd0, 0, 0, 0, 0, "beq_not_taken");
  endtask

  task automatic test_jal();
    do_instr(OP_JAL, 6'd0, 0, 1, 0, 0, "jal");
  endtask

  task automatic test_illegal();
    do_instr(6'b111111, 6'd0, 0, 0, 0, 0, "illegal_op");
    do_instr(OP_RTYPE, 6'b000111, 0, 0, 0, 0, "illegal_funct");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [8];
    logic [5:0] fns [7];
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL, 6'b010101};
    fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'b000111, 6'b111111};
    for (int n = 0; n < 60; n++) begin
      do_instr(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 6)],
               1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
               0, "random");
    end
  endtask

  task automatic test_reset_mid();
    do_instr(OP_LW, 6'd0, 0, 0, 3, 1, "lw_reset_mid");
    @(posedge clk);
    #1;
    release_reset("after_mid_reset");
    do_instr(OP_ADDI, 6'd0, 0, 1, 0, 0, "post_reset_addi");
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_lw_slow();
    test_beq();
    test_jal();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
